// File: rtl/vd_pkg.sv
// Shared definitions for the Viterbi decoder controller: trellis geometry,
// decision-word width and the controller FSM state encoding.
package vd_pkg;

  // Trellis state count and the matching state-index width.
  localparam int NS = 64;
  localparam int SW = 6;

  // One decision bit per trellis state in every survivor-memory word.
  localparam int DW = NS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    TB_RD   = 3'd2,
    TB_DATA = 3'd3,
    TB_OUT  = 3'd4
  } vd_state_e;

endpackage

// File: rtl/vd_ctrl_if.sv
// Bundle of the controller's symbol input, ACS control, survivor-memory port
// and decoded-bit output. The master modport is the controller; the slave
// modport is the datapath/environment around it.
interface vd_ctrl_if import vd_pkg::*; #(
  parameter int AW = 8
);

  // Received-symbol handshake
  logic          in_valid;
  logic          in_ready;
  logic          in_last;

  // BMC/ACS array control
  logic          acs_en;
  logic          acs_init;
  logic          acs_norm;
  logic          pm_ovf;

  // Survivor memory port
  logic          sm_wr_en;
  logic          sm_rd_en;
  logic [AW-1:0] sm_addr;
  logic [DW-1:0] sm_rdata;

  // Decoded-bit stream
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;

  // Status
  logic          busy;

  modport master (
    input  in_valid, in_last, pm_ovf, sm_rdata, out_ready,
    output in_ready, acs_en, acs_init, acs_norm,
           sm_wr_en, sm_rd_en, sm_addr,
           out_valid, out_bit, out_last, busy
  );

  modport slave (
    output in_valid, in_last, pm_ovf, sm_rdata, out_ready,
    input  in_ready, acs_en, acs_init, acs_norm,
           sm_wr_en, sm_rd_en, sm_addr,
           out_valid, out_bit, out_last, busy
  );

endinterface

// File: rtl/vd_tb_step.sv
// One traceback step: pick the current state's decision bit out of the
// survivor word and shift it in as the MSB of the predecessor state.
module vd_tb_step import vd_pkg::*; #(
  parameter int NS_P = NS
) (
  input  logic [SW-1:0]   state_i,
  input  logic [NS_P-1:0] dec_word_i,
  output logic [SW-1:0]   pred_state_o
);

  logic dec_bit;

  // Decision bit of the state currently being traced.
  assign dec_bit = dec_word_i[state_i];

  // The oldest input bit of the predecessor enters at the MSB.
  assign pred_state_o = {dec_bit, state_i[SW-1:1]};

endmodule

// File: rtl/vd_ctrl.sv
// Viterbi decoder controller: sequences the ACS array and survivor-memory
// writes while a frame is received, then walks the survivor memory backwards
// from state 0 and emits the decoded bits in reverse time order.
module vd_ctrl import vd_pkg::*; #(
  parameter int AW = 8,
  parameter int NS = vd_pkg::NS
) (
  input  logic       clk,
  input  logic       rst_n,
  vd_ctrl_if.master  bus
);

  // Address of the last symbol slot; writing it forces the frame to end.
  localparam logic [AW-1:0] LAST_ADDR = '1;

  vd_state_e     state_q,     state_d;
  logic [AW-1:0] wr_cnt_q,    wr_cnt_d;
  logic [AW-1:0] tb_addr_q,   tb_addr_d;
  logic [SW-1:0] tb_state_q,  tb_state_d;
  logic          norm_pend_q, norm_pend_d;
  logic          out_bit_q,   out_bit_d;
  logic          out_last_q,  out_last_d;

  logic          in_ready;
  logic          accept;
  logic [AW-1:0] wr_addr;
  logic          acs_en;
  logic          acs_init;
  logic          acs_norm;
  logic          sm_wr_en;
  logic          sm_rd_en;
  logic [AW-1:0] sm_addr;
  logic          out_valid;
  logic [SW-1:0] pred_state;

  vd_tb_step #(
    .NS_P (NS)
  ) u_tb_step (
    .state_i      (tb_state_q),
    .dec_word_i   (bus.sm_rdata),
    .pred_state_o (pred_state)
  );

  // Next-state and output decode for the receive / traceback sequence.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    tb_addr_d   = tb_addr_q;
    tb_state_d  = tb_state_q;
    norm_pend_d = norm_pend_q | bus.pm_ovf;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    wr_addr     = '0;
    acs_en      = 1'b0;
    acs_init    = 1'b0;
    acs_norm    = 1'b0;
    sm_wr_en    = 1'b0;
    sm_rd_en    = 1'b0;
    sm_addr     = '0;
    out_valid   = 1'b0;

    unique case (state_q)
      IDLE, RECV: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        // A new frame always starts writing at address 0.
        wr_addr  = (state_q == IDLE) ? '0 : wr_cnt_q;
        sm_addr  = wr_addr;
        if (accept) begin
          acs_en   = 1'b1;
          sm_wr_en = 1'b1;
          wr_cnt_d = wr_addr + 1'b1;
          if (state_q == IDLE) begin
            // Initial metrics replace any pending normalization.
            acs_init    = 1'b1;
            norm_pend_d = 1'b0;
          end else begin
            acs_norm    = norm_pend_q;
            norm_pend_d = bus.pm_ovf;
          end
          if (bus.in_last || (wr_addr == LAST_ADDR)) begin
            // Tail-terminated code: traceback starts from state 0 at the
            // most recently written symbol.
            state_d    = TB_RD;
            tb_addr_d  = wr_addr;
            tb_state_d = '0;
          end else begin
            state_d = RECV;
          end
        end
      end

      TB_RD: begin
        sm_rd_en = 1'b1;
        sm_addr  = tb_addr_q;
        state_d  = TB_DATA;
      end

      TB_DATA: begin
        sm_addr    = tb_addr_q;
        out_bit_d  = tb_state_q[0];
        out_last_d = (tb_addr_q == '0);
        tb_state_d = pred_state;
        state_d    = TB_OUT;
      end

      TB_OUT: begin
        sm_addr   = tb_addr_q;
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (tb_addr_q == '0) begin
            state_d = IDLE;
          end else begin
            tb_addr_d = tb_addr_q - 1'b1;
            state_d   = TB_RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      tb_addr_q   <= '0;
      tb_state_q  <= '0;
      norm_pend_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      tb_addr_q   <= tb_addr_d;
      tb_state_q  <= tb_state_d;
      norm_pend_q <= norm_pend_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.acs_en    = acs_en;
  assign bus.acs_init  = acs_init;
  assign bus.acs_norm  = acs_norm;
  assign bus.sm_wr_en  = sm_wr_en;
  assign bus.sm_rd_en  = sm_rd_en;
  assign bus.sm_addr   = sm_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit_q;
  // The registered last flag only means something while a bit is offered.
  assign bus.out_last  = out_valid & out_last_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vd_ctrl.sv
// Directed bench for vd_ctrl: frame sequencing, traceback state walk,
// normalization flag, forced frame end, backpressure and reset behaviour.
module tb_vd_ctrl;
  import vd_pkg::*;

  localparam int AW = 8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Survivor-memory contents served back to the controller on reads.
  logic [63:0] mem [256];

  vd_ctrl_if #(.AW(AW)) bus ();

  vd_ctrl #(.AW(AW), .NS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one symbol and check the same-cycle ACS / write strobes.
  task automatic send_sym(input int addr, input logic last,
                          input logic exp_init, input logic exp_norm);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    #1;
    check("sym_in_ready", bus.in_ready, 1);
    check("sym_acs_en",   bus.acs_en,   1);
    check("sym_wr_en",    bus.sm_wr_en, 1);
    check("sym_rd_en",    bus.sm_rd_en, 0);
    check("sym_addr",     bus.sm_addr,  addr);
    check("sym_init",     bus.acs_init, exp_init);
    check("sym_norm",     bus.acs_norm, exp_norm);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // One-cycle overflow report while no symbol is offered.
  task automatic ovf_pulse();
    @(negedge clk);
    bus.pm_ovf = 1'b1;
    #1;
    check("ovf_acs_en",   bus.acs_en,   0);
    check("ovf_acs_norm", bus.acs_norm, 0);
    @(posedge clk);
    #1;
    bus.pm_ovf = 1'b0;
  endtask

  // Follow one traceback step: read, data, output (optionally stalled).
  task automatic tb_bit(input int addr, input logic exp_bit,
                        input logic exp_last, input int stall);
    @(negedge clk);
    #1;
    check("rd_en",       bus.sm_rd_en, 1);
    check("rd_addr",     bus.sm_addr,  addr);
    check("rd_no_wr",    bus.sm_wr_en, 0);
    check("rd_no_acs",   bus.acs_en,   0);
    check("rd_in_ready", bus.in_ready, 0);
    bus.sm_rdata = ~mem[addr];
    @(negedge clk);
    #1;
    check("data_rd_en", bus.sm_rd_en,  0);
    check("data_valid", bus.out_valid, 0);
    bus.sm_rdata = mem[addr];
    @(negedge clk);
    #1;
    bus.sm_rdata = ~mem[addr];
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_bit",   bus.out_bit,   exp_bit);
      check("stall_last",  bus.out_last,  exp_last);
      check("stall_rd_en", bus.sm_rd_en,  0);
      @(negedge clk);
      #1;
    end
    check("out_valid", bus.out_valid, 1);
    check("out_bit",   bus.out_bit,   exp_bit);
    check("out_last",  bus.out_last,  exp_last);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_acs_en"},    bus.acs_en,    0);
    check({tag, "_acs_init"},  bus.acs_init,  0);
    check({tag, "_acs_norm"},  bus.acs_norm,  0);
    check({tag, "_wr_en"},     bus.sm_wr_en,  0);
    check({tag, "_rd_en"},     bus.sm_rd_en,  0);
    check({tag, "_addr"},      bus.sm_addr,   0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"},  bus.out_last,  0);
    check({tag, "_out_bit"},   bus.out_bit,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.pm_ovf    = 1'b0;
    bus.out_ready = 1'b0;
    bus.sm_rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: 4 symbols, all-ones decisions -> states 0,32,48,56, bits 0.
    // First output held 10 cycles; overflow reported during traceback.
    for (int i = 0; i < 4; i++) mem[i] = '1;
    for (int k = 0; k < 4; k++) send_sym(k, (k == 3), (k == 0), 1'b0);
    tb_bit(3, 1'b0, 1'b0, 10);
    tb_bit(2, 1'b0, 1'b0, 0);
    bus.pm_ovf = 1'b1;
    tb_bit(1, 1'b0, 1'b0, 0);
    bus.pm_ovf = 1'b0;
    tb_bit(0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    check("a_end_busy",     bus.busy,     0);
    check("a_end_in_ready", bus.in_ready, 1);

    // Frame B: 8 symbols, overflow between symbols 2 and 3.
    // Traced states 0,32,16,40,20,42,53,26 -> emitted bits 0,0,0,0,0,0,1,0.
    mem[7] = 64'h0000_0000_0000_0001;
    mem[6] = 64'hFFFF_FFFE_FFFF_FFFF;
    mem[5] = 64'h0000_0000_0001_0000;
    mem[4] = 64'hFFFF_FEFF_FFFF_FFFF;
    mem[3] = 64'h0000_0000_0010_0000;
    mem[2] = 64'h0000_0400_0000_0000;
    mem[1] = 64'hFFDF_FFFF_FFFF_FFFF;
    mem[0] = 64'h0123_4567_89AB_CDEF;
    send_sym(0, 1'b0, 1'b1, 1'b0);
    send_sym(1, 1'b0, 1'b0, 1'b0);
    ovf_pulse();
    send_sym(2, 1'b0, 1'b0, 1'b1);
    for (int k = 3; k < 8; k++) send_sym(k, (k == 7), 1'b0, 1'b0);
    for (int a = 7; a >= 0; a--) tb_bit(a, (a == 1), (a == 0), 0);

    // Forced frame end: 256 symbols without in_last, two more waiting.
    // All-ones decisions saturate the state at 63 after six steps.
    for (int i = 0; i < 256; i++) mem[i] = '1;
    for (int k = 0; k < 256; k++) send_sym(k, 1'b0, (k == 0), 1'b0);
    bus.in_valid = 1'b1;
    for (int a = 255; a >= 0; a--) tb_bit(a, ((255 - a) >= 6), (a == 0), 0);
    send_sym(0, 1'b0, 1'b1, 1'b0);
    send_sym(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("recv_busy", bus.busy, 1);

    // Reset in the middle of a frame.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame C: reset while a bit is offered, then no output after release.
    send_sym(0, 1'b0, 1'b1, 1'b0);
    send_sym(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("c_rd_en", bus.sm_rd_en, 1);
    check("c_rd_addr", bus.sm_addr, 1);
    bus.sm_rdata = mem[1];
    @(negedge clk);
    @(negedge clk);
    #1;
    check("c_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("tbrst");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;

    // Single-symbol frame: exactly one bit, flagged last.
    send_sym(0, 1'b1, 1'b1, 1'b0);
    tb_bit(0, 1'b0, 1'b1, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("single_idle_valid", bus.out_valid, 0);
      check("single_idle_busy",  bus.busy,      0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vd_ctrl.md
VD_CTRL -- requirements
Module: vd_ctrl

Interface
REQ-001 Parameter AW, default 8, is the survivor-memory address width; maximum frame length FRAME_MAX = 2^AW symbols.
REQ-002 Parameter NS, default 64, is the trellis state count; it is fixed at 64 (6-bit state).
REQ-003 clk  input  1  single clock; all flops rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  received symbol pair available.
REQ-006 in_ready  output  1  controller accepts a symbol this cycle.
REQ-007 in_last  input  1  qualifies the accepted symbol as last of frame.
REQ-008 acs_en  output  1  one-cycle pulse: BMC/ACS array updates on the accepted symbol.
REQ-009 acs_init  output  1  with acs_en: ACS loads initial metrics (state 0 = 0, others = max).
REQ-010 acs_norm  output  1  with acs_en: ACS subtracts normalization offset.
REQ-011 pm_ovf  input  1  ACS reports a path-metric MSB set.
REQ-012 sm_wr_en  output  1  write the ACS 64-bit decision word at sm_addr.
REQ-013 sm_rd_en  output  1  read survivor memory at sm_addr; data valid next cycle.
REQ-014 sm_addr  output  AW  survivor memory address.
REQ-015 sm_rdata  input  64  decision word; bit s = decision of state s.
REQ-016 out_valid / out_ready / out_bit / out_last  output/input/output/output  1 each  decoded-bit stream, valid/ready handshake.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RECV, TB_RD, TB_DATA, TB_OUT.
REQ-019 in_ready SHALL be 1 in IDLE and RECV, 0 in all traceback states.
REQ-020 An accepted symbol (in_valid & in_ready) SHALL assert acs_en and sm_wr_en combinationally in the same cycle, with sm_addr = wr_cnt, then increment wr_cnt.
REQ-021 acs_init SHALL be asserted only with the acceptance in IDLE (first symbol of frame); IDLE resets wr_cnt to 0 on that acceptance.
REQ-022 IDLE -> RECV on acceptance without in_last; IDLE or RECV -> TB_RD on acceptance with in_last or when wr_cnt = FRAME_MAX-1 (forced frame end).
REQ-023 On entry to TB_RD, tb_addr SHALL equal the address of the last written symbol and tb_state SHALL be 0 (tail-terminated code).
REQ-024 TB_RD: assert sm_rd_en with sm_addr = tb_addr for exactly one cycle, go TB_DATA.
REQ-025 TB_DATA: register out_bit = tb_state[0]; update tb_state = {sm_rdata[tb_state], tb_state[5:1]}; go TB_OUT.
REQ-026 TB_OUT: out_valid = 1, out_bit/out_last stable until out_ready; on handshake, if tb_addr = 0 go IDLE, else decrement tb_addr and go TB_RD.
REQ-027 out_last SHALL be 1 only for the bit read from address 0; bits are emitted in reverse time order.
REQ-028 A pm_ovf pulse SHALL set a sticky norm_pend flag; acs_norm = norm_pend & acs_en; norm_pend clears on that acs_en unless pm_ovf is high again in the same cycle.
REQ-029 pm_ovf in traceback states SHALL still latch norm_pend, which is cleared on the acceptance in IDLE (acs_init supersedes normalization) and acs_norm is 0 on it.
REQ-030 sm_wr_en and sm_rd_en SHALL never be asserted in the same cycle.
REQ-031 Single-symbol frame (in_last on first acceptance) SHALL produce exactly one output bit with out_last = 1.

Reset
REQ-032 rst_n low SHALL force state IDLE, wr_cnt = 0, tb_addr = 0, tb_state = 0, norm_pend = 0, out_bit = 0; outputs acs_en, acs_init, acs_norm, sm_wr_en, sm_rd_en, out_valid, out_last, busy = 0, sm_addr = 0, in_ready = 1.
REQ-033 Reset mid-frame or mid-traceback SHALL abandon the frame; no output bits follow reset release until a new frame completes.

Structure
REQ-034 A shared package vd_pkg SHALL hold NS, state width (6), decision-word width (64) and the FSM state enumeration.
REQ-035 One sub-module vd_tb_step SHALL hold the combinational traceback step (decision-bit select and predecessor-state computation).

Verification
REQ-036 Frame of 4 symbols, in_last on 4th -> sm_addr 0,1,2,3 written, acs_init only on first, then reads at 3,2,1,0 with out_last on the 4th bit.
REQ-037 sm_rdata all-ones for all reads, 4-symbol frame -> tb_state 0 -> 32 -> 48 -> 56; out_bit sequence 0,0,0,0.
REQ-038 258 symbols without in_last (AW = 8) -> forced end after 256th acceptance, in_ready = 0 on cycle after; symbols 257-258 held until IDLE.
REQ-039 pm_ovf pulse between symbols 2 and 3 -> acs_norm asserted with symbol 3 acs_en only.
REQ-040 out_ready held low 10 cycles in TB_OUT -> out_valid, out_bit stable, no sm_rd_en; rst_n low in TB_OUT -> all outputs at reset values, no out_valid after release.
